// File: rtl/cache_fill.sv
// cache_fill: single-line miss handler for a cache.
// A miss is accepted in IDLE, issued to memory (REQ), its read data is
// awaited (WAIT) and then written into the cache and returned (FILL).
// A flush during an outstanding fill suppresses the cache write but still
// returns the data to the requester.
// Optional feature macro: CACHE_FILL_TIMEOUT_EN adds a WAIT-cycle counter
// and an ERR response when memory does not answer within TIMEOUT cycles.
module cache_fill #(
    parameter int ADDR_WIDTH = 20,
    parameter int D_WIDTH    = 20,
    parameter int TIMEOUT    = 255
) (
    input  logic                  CLK,
    input  logic                  RST_X,
    input  logic                  w_flush,
    input  logic                  w_miss_valid,
    output logic                  w_miss_ready,
    input  logic [ADDR_WIDTH-1:0] w_miss_addr,
    output logic                  w_mem_req,
    input  logic                  w_mem_gnt,
    output logic [ADDR_WIDTH-1:0] w_mem_addr,
    input  logic                  w_mem_rvalid,
    input  logic [D_WIDTH-1:0]    w_mem_rdata,
    output logic                  w_fill_we,
    output logic [ADDR_WIDTH-1:0] w_fill_addr,
    output logic [D_WIDTH-1:0]    w_fill_data,
    output logic                  w_rsp_valid,
    output logic [D_WIDTH-1:0]    w_rsp_data,
    output logic                  w_rsp_err
);

`ifdef CACHE_FILL_TIMEOUT_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_FILL, S_ERR} state_t;
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FILL} state_t;
`endif

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [D_WIDTH-1:0]    r_data;
    logic                  r_drop;
    logic                  r_miss_ready;
    logic                  r_mem_req;
    logic                  r_rsp_valid;
    logic                  r_fill;
`ifdef CACHE_FILL_TIMEOUT_EN
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_err;
`endif

    // Miss-handling FSM; every output flag is registered alongside the state
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_data       <= '0;
            r_drop       <= 1'b0;
            r_miss_ready <= 1'b1;
            r_mem_req    <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_fill       <= 1'b0;
`ifdef CACHE_FILL_TIMEOUT_EN
            r_cnt        <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            // response-side flags are single-cycle pulses by default
            r_rsp_valid <= 1'b0;
            r_fill      <= 1'b0;
`ifdef CACHE_FILL_TIMEOUT_EN
            r_err       <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_miss_valid) begin
                        r_addr       <= w_miss_addr;
                        r_state      <= S_REQ;
                        r_miss_ready <= 1'b0;
                        r_mem_req    <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (w_flush) r_drop <= 1'b1;
                    if (w_mem_gnt) begin
                        r_state   <= S_WAIT;
                        r_mem_req <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (w_flush) r_drop <= 1'b1;
                    // read data beats the timeout when both land together
                    if (w_mem_rvalid) begin
                        r_data      <= w_mem_rdata;
                        r_state     <= S_FILL;
                        r_rsp_valid <= 1'b1;
                        r_fill      <= 1'b1;
`ifdef CACHE_FILL_TIMEOUT_EN
                        r_cnt       <= '0;
                    end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                        r_state     <= S_ERR;
                        r_rsp_valid <= 1'b1;
                        r_err       <= 1'b1;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt       <= r_cnt + 1'b1;
`endif
                    end
                end
                S_FILL: begin
                    r_state      <= S_IDLE;
                    r_drop       <= 1'b0;
                    r_miss_ready <= 1'b1;
                end
`ifdef CACHE_FILL_TIMEOUT_EN
                S_ERR: begin
                    r_state      <= S_IDLE;
                    r_drop       <= 1'b0;
                    r_miss_ready <= 1'b1;
                end
`endif
                default: begin
                    r_state      <= S_IDLE;
                    r_drop       <= 1'b0;
                    r_miss_ready <= 1'b1;
                    r_mem_req    <= 1'b0;
                end
            endcase
        end
    end

    assign w_miss_ready = r_miss_ready;
    assign w_mem_req    = r_mem_req;
    assign w_mem_addr   = r_addr;
    assign w_rsp_valid  = r_rsp_valid;
    // error responses carry zero data
    assign w_rsp_data   = r_fill ? r_data : '0;
    assign w_fill_addr  = r_addr;
    assign w_fill_data  = r_data;
    // a flush seen earlier in the transaction or in the fill cycle itself
    // keeps possibly stale data out of the cache
    assign w_fill_we    = r_fill & ~r_drop & ~w_flush;
`ifdef CACHE_FILL_TIMEOUT_EN
    assign w_rsp_err    = r_err;
`else
    // no error source exists without the timeout; TIMEOUT is legal only
    // when non-negative, so this is constant 0
    assign w_rsp_err    = (TIMEOUT < 0);
`endif

endmodule
